// File: rtl/mul_pkg.sv
// mul_pkg: shared state encoding and default sizing for the multiplier path.
// Used by mul_host_adapter, its interface and the optional watchdog.
package mul_pkg;

   localparam int MUL_WIDTH   = 6;
   localparam int MUL_TIMEOUT = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_SEND_A,
      ST_SEND_B,
      ST_WAIT,
      ST_GET_LO,
      ST_RESP
   } mul_state_t;

endpackage

// File: rtl/mul_host_adapter_if.sv
// mul_host_adapter_if: host request/response handshake plus the
// serial operand/product bus towards the Booth multiplier.
interface mul_host_adapter_if
   import mul_pkg::*;
#(
   parameter int WIDTH = MUL_WIDTH
);

   logic               req_valid;
   logic               req_ready;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic               res_valid;
   logic               res_ready;
   logic [2*WIDTH-1:0] result;
   logic               res_err;
   logic               mul_start;
   logic [WIDTH-1:0]   mul_in;
   logic [WIDTH-1:0]   mul_out;
   logic               mul_done;

   modport slave (
      input  req_valid,
      input  op_a,
      input  op_b,
      input  res_ready,
      input  mul_out,
      input  mul_done,
      output req_ready,
      output res_valid,
      output result,
      output res_err,
      output mul_start,
      output mul_in
   );

   modport master (
      output req_valid,
      output op_a,
      output op_b,
      output res_ready,
      output mul_out,
      output mul_done,
      input  req_ready,
      input  res_valid,
      input  result,
      input  res_err,
      input  mul_start,
      input  mul_in
   );

endinterface

// File: rtl/mul_host_adapter_watchdog.sv
// mul_watchdog: counts WAIT cycles and flags expiry after TIMEOUT of them.
// Only instantiated when MUL_TIMEOUT_EN is defined.
module mul_watchdog
   import mul_pkg::*;
#(
   parameter int TIMEOUT = MUL_TIMEOUT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0] cnt_q;

   assign expired = run && (cnt_q == CW'(TIMEOUT - 1));

   // count while running, hold at expiry, clear whenever not running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!run) begin
         cnt_q <= '0;
      end else if (!expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/mul_host_adapter.sv
// mul_host_adapter: feeds an operand pair to a Booth multiplier and returns {hi,lo}.
// Optional macro MUL_TIMEOUT_EN adds a WAIT-state watchdog abort with res_err.
module mul_host_adapter
   import mul_pkg::*;
#(
   parameter int WIDTH   = MUL_WIDTH,
   parameter int TIMEOUT = MUL_TIMEOUT
) (
   input logic               clk,
   input logic               rst_n,
   mul_host_adapter_if.slave bus
);

   mul_state_t         state_q;
   mul_state_t         state_d;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [2*WIDTH-1:0] res_q;
   logic               hs_req;
   logic               cap_hi;
   logic               cap_lo;

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("mul_host_adapter: TIMEOUT must be at least 1");
   end

   assign hs_req = (state_q == ST_IDLE) && bus.req_valid;
   assign cap_hi = (state_q == ST_WAIT) && bus.mul_done;
   assign cap_lo = (state_q == ST_GET_LO);

`ifdef MUL_TIMEOUT_EN
   logic expired;
   logic abort;
   logic err_q;

   mul_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_wdog (
      .clk     (clk),
      .rst_n   (rst_n),
      .run     (state_q == ST_WAIT),
      .expired (expired)
   );

   // a completion in the expiry cycle still wins over the abort
   assign abort = (state_q == ST_WAIT) && !bus.mul_done && expired;

   // error flag: cleared on a new request, set on abort
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if (hs_req) begin
         err_q <= 1'b0;
      end else if (abort) begin
         err_q <= 1'b1;
      end
   end

   assign bus.res_err = err_q;
`else
   assign bus.res_err = 1'b0;
`endif

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state: fixed send sequence, then wait for the multiplier
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (bus.req_valid) state_d = ST_START;
         ST_START:  state_d = ST_SEND_A;
         ST_SEND_A: state_d = ST_SEND_B;
         ST_SEND_B: state_d = ST_WAIT;
         ST_WAIT: begin
            if (bus.mul_done) begin
               state_d = ST_GET_LO;
`ifdef MUL_TIMEOUT_EN
            end else if (abort) begin
               state_d = ST_RESP;
`endif
            end
         end
         ST_GET_LO: state_d = ST_RESP;
         ST_RESP:   if (bus.res_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // operand latch on request handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
      end else if (hs_req) begin
         a_q <= bus.op_a;
         b_q <= bus.op_b;
      end
   end

   // product capture: high half on completion, low half one cycle later
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_q <= '0;
      end else if (cap_hi) begin
         res_q[2*WIDTH-1:WIDTH] <= bus.mul_out;
      end else if (cap_lo) begin
         res_q[WIDTH-1:0] <= bus.mul_out;
`ifdef MUL_TIMEOUT_EN
      end else if (abort) begin
         res_q <= '0;
`endif
      end
   end

   // outputs decode only from registered state and data
   always_comb begin
      bus.req_ready = 1'b0;
      bus.res_valid = 1'b0;
      bus.mul_start = 1'b0;
      bus.mul_in    = '0;
      unique case (state_q)
         ST_IDLE:   bus.req_ready = 1'b1;
         ST_START:  bus.mul_start = 1'b1;
         ST_SEND_A: bus.mul_in    = a_q;
         ST_SEND_B: bus.mul_in    = b_q;
         ST_RESP:   bus.res_valid = 1'b1;
         default:   ;
      endcase
   end

   assign bus.result = res_q;

endmodule

// File: tb/tb_mul_host_adapter.sv
// tb_mul_host_adapter: adapter paired with a behavioural Booth multiplier model.
// Define MUL_TIMEOUT_EN to also exercise the watchdog abort with TIMEOUT=8.
module tb_mul_host_adapter;
   import mul_pkg::*;

   localparam int W = MUL_WIDTH;
`ifdef MUL_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = MUL_TIMEOUT;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   mul_host_adapter_if #(.WIDTH(W)) bus ();

   mul_host_adapter #(
      .WIDTH   (W),
      .TIMEOUT (TO)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic signed [W-1:0] a;
      logic signed [W-1:0] b;
      int                  lat;
      int                  hold;
      logic [2*W-1:0]      exp;
   } vec_t;

   vec_t tbl [4];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [2*W-1:0] ref_mul(input logic signed [W-1:0] a,
                                              input logic signed [W-1:0] b);
      int ia;
      int ib;
      ia = a;
      ib = b;
      return (2*W)'(ia * ib);
   endfunction

   task automatic accept(input logic signed [W-1:0] a,
                         input logic signed [W-1:0] b);
      int n;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.op_a = a;
      bus.op_b = b;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      chk("start_pulse", {bus.mul_start, bus.req_ready}, 32'b10);
      chk("start_in_zero", 32'(bus.mul_in), 32'd0);
   endtask

   task automatic run_txn(input logic signed [W-1:0] a,
                          input logic signed [W-1:0] b,
                          input int lat, input int hold,
                          input logic [2*W-1:0] exp);
      logic signed [W-1:0] ma;
      logic signed [W-1:0] mb;
      logic [2*W-1:0]      p;
      accept(a, b);
      @(negedge clk);
      chk("send_a_nostart", 32'(bus.mul_start), 32'd0);
      ma = bus.mul_in;
      chk("send_a", 32'(ma), 32'(a));
      @(negedge clk);
      mb = bus.mul_in;
      chk("send_b", 32'(mb), 32'(b));
      p = ref_mul(ma, mb);
      for (int i = 0; i <= lat; i++) begin
         @(negedge clk);
         chk("wait_quiet", {bus.res_valid, bus.mul_start, bus.mul_in}, 32'd0);
         if (i == lat) begin
            bus.mul_done = 1'b1;
            bus.mul_out = p[2*W-1:W];
         end
      end
      @(negedge clk);
      chk("getlo_novalid", 32'(bus.res_valid), 32'd0);
      bus.mul_done = 1'($urandom);
      bus.mul_out = p[W-1:0];
      @(negedge clk);
      bus.mul_done = 1'($urandom);
      bus.mul_out = W'($urandom);
      chk("res_valid", 32'(bus.res_valid), 32'd1);
      chk("result", 32'(bus.result), 32'(exp));
      chk("res_err", 32'(bus.res_err), 32'd0);
      for (int i = 0; i < hold; i++) begin
         bus.req_valid = 1'b1;
         @(negedge clk);
         bus.mul_done = 1'($urandom);
         chk("hold_result", 32'(bus.result), 32'(exp));
         chk("hold_flags", {bus.res_valid, bus.req_ready}, 32'b10);
      end
      bus.res_ready = 1'b1;
      bus.req_valid = 1'b1;
      @(negedge clk);
      chk("back_idle", {bus.res_valid, bus.req_ready, bus.mul_start}, 32'b010);
      bus.res_ready = 1'b0;
      bus.req_valid = 1'b0;
      bus.mul_done = 1'b0;
      bus.mul_out = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "tb timeout");
   end

   initial begin
      logic signed [W-1:0] ra;
      logic signed [W-1:0] rb;

      bus.req_valid = 1'b0;
      bus.op_a = '0;
      bus.op_b = '0;
      bus.res_ready = 1'b0;
      bus.mul_out = '0;
      bus.mul_done = 1'b0;

      tbl[0] = '{a: 6'sd23,  b: -6'sd11, lat: 0, hold: 0,  exp: 12'hF03};
      tbl[1] = '{a: 6'sd9,   b: 6'sd8,   lat: 2, hold: 1,  exp: 12'h048};
      tbl[2] = '{a: -6'sd10, b: -6'sd19, lat: 1, hold: 0,  exp: 12'h0BE};
      tbl[3] = '{a: 6'sd20,  b: 6'sd0,   lat: 3, hold: 10, exp: 12'h000};

      repeat (3) @(negedge clk);
      chk("rst_result", 32'(bus.result), 32'd0);
      chk("rst_outs", {bus.res_valid, bus.res_err, bus.mul_start}, 32'd0);
      chk("rst_mul_in", 32'(bus.mul_in), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 32'(bus.req_ready), 32'd1);

      for (int i = 0; i < 4; i++)
         run_txn(tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].hold, tbl[i].exp);

      for (int i = 0; i < 20; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         run_txn(ra, rb, int'($urandom_range(0, 4)),
                 int'($urandom_range(0, 3)), ref_mul(ra, rb));
      end

      // stray mul_done in IDLE and SEND_A, then reset in WAIT
      @(negedge clk);
      bus.mul_done = 1'b1;
      bus.mul_out = 6'h2A;
      @(negedge clk);
      bus.mul_done = 1'b0;
      chk("idle_done_ignored", {bus.res_valid, bus.req_ready, bus.mul_start}, 32'b010);
      accept(6'sd5, 6'sd7);
      bus.mul_done = 1'b1;
      @(negedge clk);
      bus.mul_done = 1'b0;
      chk("senda_done_ignored", 32'(bus.mul_in), 32'd5);
      @(negedge clk);
      chk("sendb_in", 32'(bus.mul_in), 32'd7);
      repeat (2) @(negedge clk);
      chk("wait_no_valid", 32'(bus.res_valid), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("abort_result", 32'(bus.result), 32'd0);
      chk("abort_outs", {bus.res_valid, bus.mul_start, bus.mul_in}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_abort", {bus.res_valid, bus.req_ready, bus.mul_start}, 32'b010);
      end

`ifdef MUL_TIMEOUT_EN
      accept(6'sd3, 6'sd3);
      repeat (2) @(negedge clk);
      for (int i = 0; i < TO; i++) begin
         @(negedge clk);
         chk("to_waiting", 32'(bus.res_valid), 32'd0);
      end
      @(negedge clk);
      chk("to_valid", 32'(bus.res_valid), 32'd1);
      chk("to_err", 32'(bus.res_err), 32'd1);
      chk("to_result", 32'(bus.result), 32'd0);
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      chk("to_idle", 32'(bus.req_ready), 32'd1);
`endif

      run_txn(-6'sd32, -6'sd32, 0, 0, 12'h400);
      run_txn(6'sd31, -6'sd32, 1, 0, 12'hC20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
